instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch unit with a single-outstanding memory request
//            FSM and a small prefetch FIFO feeding decode. A branch flushes the
//            FIFO and redirects the fetch stream. A response that is already
//            in flight when the branch arrives is discarded.
// Options  : FETCH_STALL_CNT_EN enables the saturating decode-starvation
//            counter. When it is undefined, stall_cnt_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [15:0] stall_cnt_o
);

  localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // IDLE: no request. REQ: request driven, awaiting grant.
  // WAIT: granted, awaiting data. DROP: granted, but the data is stale.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      pend_pc;
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             resp_accept;
  logic             push;
  logic             pop;
  logic             can_req;
  logic [31:0]      push_pc;
  logic [31:0]      branch_target;
  logic             unused_branch_lsbs;

  assign branch_target      = {branch_addr_i[31:2], 2'b00};
  assign unused_branch_lsbs = ^branch_addr_i[1:0];

  // The head comes from FIFO storage registers, so it never passes rdata through combinationally.
  assign fetch_valid_o = (count != '0);
  assign fetch_instr_o = fifo_instr[rd_ptr];
  assign fetch_pc_o    = fifo_pc[rd_ptr];

  // Response acceptance, FIFO push/pop and occupancy bookkeeping; a branch wins over both.
  always_comb begin
    resp_accept = 1'b0;
    push_pc     = pend_pc;
    case (state)
      REQ: begin
        resp_accept = instr_gnt_i & instr_rvalid_i;
        push_pc     = instr_addr_o;
      end
      WAIT:    resp_accept = instr_rvalid_i;
      default: resp_accept = 1'b0;
    endcase
    pop  = fetch_valid_o & fetch_ready_i & ~branch_i;
    push = resp_accept & ~branch_i & ((count != DEPTH_CNT) | pop);
    if (branch_i) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
    // The upcoming request is the only one in flight, so the FIFO just needs a free slot.
    can_req = (count_next < DEPTH_CNT);
  end

  // Next-state selection for the request FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (can_req) state_next = REQ;
      end
      REQ: begin
        if (instr_gnt_i) begin
          if (instr_rvalid_i)  state_next = can_req ? REQ : IDLE;
          else if (branch_i)   state_next = DROP;
          else                 state_next = WAIT;
        end
      end
      WAIT: begin
        if (instr_rvalid_i)    state_next = can_req ? REQ : IDLE;
        else if (branch_i)     state_next = DROP;
      end
      DROP: begin
        if (instr_rvalid_i)    state_next = can_req ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, registered request and fetch address; the address advances on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      instr_req_o  <= 1'b0;
      instr_addr_o <= BOOT_ADDR;
      pend_pc      <= 32'h0;
    end else begin
      state       <= state_next;
      instr_req_o <= (state_next == REQ);
      if (branch_i) begin
        instr_addr_o <= branch_target;
      end else if ((state == REQ) && instr_gnt_i) begin
        instr_addr_o <= instr_addr_o + 32'd4;
      end
      if ((state == REQ) && instr_gnt_i) begin
        pend_pc <= instr_addr_o;
      end
    end
  end

  // Prefetch FIFO storage and pointers; a branch empties it in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= 32'h0;
        fifo_pc[i]    <= 32'h0;
      end
    end else begin
      count <= count_next;
      if (branch_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= instr_rdata_i;
          fifo_pc[wr_ptr]    <= push_pc;
          wr_ptr             <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        end
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Count cycles where decode is ready but has nothing to take; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0;
    end else if (fetch_ready_i && !fetch_valid_o && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [15:0] stall_cnt_o;

  logic        mem_comb;
  logic [31:0] rdata_drv;
  int          checks;
  int          errors;
  logic [15:0] exp_stall;

  // Memory model: the word at an address is its bitwise inverse.
  assign instr_rdata_i = mem_comb ? ~instr_addr_o : rdata_drv;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_instr_o  (fetch_instr_o),
    .fetch_pc_o     (fetch_pc_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = 32'h0;
    fetch_ready_i  = 1'b0;
    mem_comb       = 1'b0;
    rdata_drv      = 32'h0;
`ifdef FETCH_STALL_CNT_EN
    exp_stall = 16'd2;
`else
    exp_stall = 16'd0;
`endif

    tick();
    tick();
    chk("rst_req",   {31'h0, instr_req_o},   32'h0);
    chk("rst_addr",  instr_addr_o,           32'h0);
    chk("rst_valid", {31'h0, fetch_valid_o}, 32'h0);
    chk("rst_instr", fetch_instr_o,          32'h0);
    chk("rst_pc",    fetch_pc_o,             32'h0);
    chk("rst_stall", {16'h0, stall_cnt_o},   32'h0);

    // Streaming from a zero-latency memory with decode always ready.
    rst            = 1'b0;
    fetch_ready_i  = 1'b1;
    instr_gnt_i    = 1'b1;
    instr_rvalid_i = 1'b1;
    mem_comb       = 1'b1;
    tick();
    chk("boot_req",   {31'h0, instr_req_o},   32'h1);
    chk("boot_addr",  instr_addr_o,           32'h0);
    chk("boot_valid", {31'h0, fetch_valid_o}, 32'h0);
    tick();
    chk("stream_v0",  {31'h0, fetch_valid_o}, 32'h1);
    chk("stream_pc0", fetch_pc_o,             32'h0);
    chk("stream_i0",  fetch_instr_o,          32'hFFFF_FFFF);
    chk("stall_cnt",  {16'h0, stall_cnt_o},   {16'h0, exp_stall});
    tick();
    chk("stream_pc1", fetch_pc_o,             32'h4);
    chk("stream_i1",  fetch_instr_o,          32'hFFFF_FFFB);
    tick();
    chk("stream_pc2", fetch_pc_o,             32'h8);
    chk("stall_hold", {16'h0, stall_cnt_o},   {16'h0, exp_stall});

    // Reset in the middle of streaming, then let the FIFO fill with decode stalled.
    rst = 1'b1;
    tick();
    chk("rst2_valid", {31'h0, fetch_valid_o}, 32'h0);
    chk("rst2_req",   {31'h0, instr_req_o},   32'h0);
    rst           = 1'b0;
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("full_req",   {31'h0, instr_req_o},   32'h0);
    chk("full_addr",  instr_addr_o,           32'h8);
    chk("full_pc",    fetch_pc_o,             32'h0);
    chk("full_valid", {31'h0, fetch_valid_o}, 32'h1);

    // Consume one entry; a request to 0x8 follows.
    fetch_ready_i = 1'b1;
    tick();
    chk("pop_pc",  fetch_pc_o,           32'h4);
    chk("pop_req", {31'h0, instr_req_o}, 32'h1);

    // Grant withheld for three cycles: the request holds steady.
    fetch_ready_i  = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req",  {31'h0, instr_req_o}, 32'h1);
      chk("hold_addr", instr_addr_o,         32'h8);
    end

    // Grant without data puts the FSM into WAIT.
    instr_gnt_i = 1'b1;
    tick();
    chk("wait_req",  {31'h0, instr_req_o}, 32'h0);
    chk("wait_addr", instr_addr_o,         32'hC);

    // Branch while waiting: flush and redirect to the aligned target.
    instr_gnt_i   = 1'b0;
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0102;
    tick();
    chk("br_valid", {31'h0, fetch_valid_o}, 32'h0);
    chk("br_addr",  instr_addr_o,           32'h100);
    chk("br_req",   {31'h0, instr_req_o},   32'h0);

    // The stale response arrives and is dropped.
    branch_i       = 1'b0;
    instr_rvalid_i = 1'b1;
    mem_comb       = 1'b0;
    rdata_drv      = 32'hDEAD_BEEF;
    tick();
    chk("drop_valid", {31'h0, fetch_valid_o}, 32'h0);
    chk("drop_req",   {31'h0, instr_req_o},   32'h1);
    chk("drop_addr",  instr_addr_o,           32'h100);

    instr_gnt_i = 1'b1;
    mem_comb    = 1'b1;
    tick();
    chk("tgt_valid", {31'h0, fetch_valid_o}, 32'h1);
    chk("tgt_pc",    fetch_pc_o,             32'h100);
    chk("tgt_instr", fetch_instr_o,          32'hFFFF_FEFF);

    // Branch to the top word: the address must wrap to zero after its grant.
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    branch_i       = 1'b1;
    branch_addr_i  = 32'hFFFF_FFFE;
    tick();
    chk("top_valid", {31'h0, fetch_valid_o}, 32'h0);
    chk("top_req",   {31'h0, instr_req_o},   32'h1);
    chk("top_addr",  instr_addr_o,           32'hFFFF_FFFC);
    branch_i       = 1'b0;
    instr_gnt_i    = 1'b1;
    instr_rvalid_i = 1'b1;
    tick();
    chk("wrap_addr",  instr_addr_o,  32'h0);
    chk("wrap_pc",    fetch_pc_o,    32'hFFFF_FFFC);
    chk("wrap_instr", fetch_instr_o, 32'h0000_0003);

    // Branch coinciding with grant+data and decode ready: branch wins.
    fetch_ready_i = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0040;
    tick();
    chk("brg_valid", {31'h0, fetch_valid_o}, 32'h0);
    chk("brg_req",   {31'h0, instr_req_o},   32'h1);
    chk("brg_addr",  instr_addr_o,           32'h40);
    branch_i      = 1'b0;
    fetch_ready_i = 1'b0;
    tick();
    chk("brg_pc",    fetch_pc_o,             32'h40);
    chk("brg_v",     {31'h0, fetch_valid_o}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
